// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and parameter checks for the UART RX frame checker
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic bit params_ok(input int data_width, input int stop_bits, input int samples);
    return (data_width >= 5) && (data_width <= 9) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (samples >= 1) && (samples <= 7) && ((samples % 2) == 1);
  endfunction

endpackage

// File: rtl/uart_maj_vote.sv
// rtl/uart_maj_vote.sv - majority vote over SAMPLES line samples per bit
module uart_maj_vote
  import uart_pkg::*;
#(
  parameter int SAMPLES = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic samp_valid,
  input  logic samp_bit,
  output logic bit_done,
  output logic bit_val
);

  localparam int CNT_W = $clog2(SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(SAMPLES / 2);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ones;
  logic [CNT_W-1:0] w_ones_tot;

  // The resolving sample is folded in combinationally so the bit is known in its own cycle
  assign w_ones_tot = r_ones + CNT_W'(samp_bit);
  assign bit_done   = samp_valid && !clr && (r_cnt == CNT_LAST);
  assign bit_val    = (w_ones_tot > HALF);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt  <= '0;
      r_ones <= '0;
    end else if (clr || bit_done) begin
      r_cnt  <= '0;
      r_ones <= '0;
    end else if (samp_valid) begin
      r_cnt  <= r_cnt + 1'b1;
      r_ones <= w_ones_tot;
    end
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// rtl/uart_rx_frame_check.sv - UART RX frame walker: start/data/parity/stop with error flags
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int SAMPLES    = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  abort,
  input  logic                  samp_valid,
  input  logic                  samp_bit,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic             STP_LAST = 1'(STOP_BITS - 1);

  generate
    if (!params_ok(DATA_WIDTH, STOP_BITS, SAMPLES)) begin : g_bad_params
      $error("uart_rx_frame_check: parameter out of range");
    end
  endgenerate

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_stp_cnt;
  logic [DATA_WIDTH-1:0]   r_shreg;
  logic                    r_par_en;
  logic                    r_par_typ;
  logic                    r_par_fail;
  logic                    r_stp_fail;

  logic w_bit_done;
  logic w_bit_val;
  logic w_vote_clr;
  logic w_start_ok;
  logic w_to_data;
  logic w_glitch;
  logic w_data_bit;
  logic w_par_bit;
  logic w_stop_bit;
  logic w_frame_end;
  logic w_par_expect;
  logic w_par_fail_next;
  logic w_stp_fail_next;

  // Vote state is held clear while idle so stray samples never leak into the next frame
  assign w_vote_clr = (r_state == ST_IDLE) || abort;

  uart_maj_vote #(
    .SAMPLES(SAMPLES)
  ) u_vote (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (w_vote_clr),
    .samp_valid(samp_valid),
    .samp_bit  (samp_bit),
    .bit_done  (w_bit_done),
    .bit_val   (w_bit_val)
  );

  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_to_data    = 1'b0;
    w_glitch     = 1'b0;
    w_data_bit   = 1'b0;
    w_par_bit    = 1'b0;
    w_stop_bit   = 1'b0;
    w_frame_end  = 1'b0;
    if (abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            w_state_next = ST_START;
            w_start_ok   = 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            if (w_bit_val) begin
              w_glitch     = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_to_data    = 1'b1;
              w_state_next = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            w_data_bit = 1'b1;
            if (r_idx == IDX_LAST) w_state_next = r_par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            w_par_bit    = 1'b1;
            w_state_next = ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            w_stop_bit = 1'b1;
            if (r_stp_cnt == STP_LAST) begin
              w_frame_end  = 1'b1;
              w_state_next = ST_IDLE;
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_par_expect    = (r_par_typ == PAR_ODD) ? ~^r_shreg : ^r_shreg;
  assign w_par_fail_next = r_par_fail | (w_par_bit & (w_bit_val != w_par_expect));
  assign w_stp_fail_next = r_stp_fail | (w_stop_bit & ~w_bit_val);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_idx       <= '0;
      r_stp_cnt   <= 1'b0;
      r_shreg     <= '0;
      r_par_en    <= 1'b0;
      r_par_typ   <= 1'b0;
      r_par_fail  <= 1'b0;
      r_stp_fail  <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      r_par_fail  <= w_par_fail_next;
      r_stp_fail  <= w_stp_fail_next;
      // Parity mode is sampled once per frame; later changes on the pins are ignored
      if (w_start_ok) begin
        r_idx      <= '0;
        r_stp_cnt  <= 1'b0;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_par_fail <= 1'b0;
        r_stp_fail <= 1'b0;
      end
      if (w_to_data) r_idx <= '0;
      if (w_data_bit) begin
        r_shreg[r_idx] <= w_bit_val;
        if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
      end
      if (w_stop_bit && !w_frame_end) r_stp_cnt <= r_stp_cnt + 1'b1;
      if (w_glitch) strt_glitch <= 1'b1;
      if (w_frame_end) begin
        par_err    <= w_par_fail_next;
        stp_err    <= w_stp_fail_next;
        data_valid <= !(w_par_fail_next || w_stp_fail_next);
        if (!(w_par_fail_next || w_stp_fail_next)) P_DATA <= r_shreg;
      end
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb/tb_uart_rx_frame_check.sv - directed self-checking bench for uart_rx_frame_check
module tb_uart_rx_frame_check;

  logic       CLK = 1'b0;
  logic       RST;
  logic       frame_start, frame_start2, abort, samp_valid, samp_bit, PAR_EN, PAR_TYP;
  logic [7:0] P_DATA, P_DATA2;
  logic       data_valid, strt_glitch, par_err, stp_err, busy;
  logic       data_valid2, strt_glitch2, par_err2, stp_err2, busy2;

  int n_chk = 0;
  int n_err = 0;
  int n_dv = 0, n_gl = 0, n_pe = 0, n_se = 0;
  int b_dv, b_gl, b_pe, b_se;

  always #5 CLK = ~CLK;

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .SAMPLES(3)) dut (
    .CLK(CLK), .RST(RST), .frame_start(frame_start), .abort(abort),
    .samp_valid(samp_valid), .samp_bit(samp_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .data_valid(data_valid), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .SAMPLES(3)) dut2 (
    .CLK(CLK), .RST(RST), .frame_start(frame_start2), .abort(abort),
    .samp_valid(samp_valid), .samp_bit(samp_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA2), .data_valid(data_valid2), .strt_glitch(strt_glitch2),
    .par_err(par_err2), .stp_err(stp_err2), .busy(busy2)
  );

  always @(posedge CLK) begin
    #1;
    if (data_valid)  n_dv++;
    if (strt_glitch) n_gl++;
    if (par_err)     n_pe++;
    if (stp_err)     n_se++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_dv = n_dv; b_gl = n_gl; b_pe = n_pe; b_se = n_se;
  endtask

  task automatic samp(input logic b);
    samp_valid = 1'b1;
    samp_bit   = b;
    @(negedge CLK);
    samp_valid = 1'b0;
    samp_bit   = 1'b0;
  endtask

  task automatic bit3(input logic b);
    samp(b); samp(b); samp(b);
  endtask

  task automatic data_bits(input logic [7:0] d);
    for (int i = 0; i < 8; i++) bit3(d[i]);
  endtask

  task automatic start_frame(input bit second);
    if (second) frame_start2 = 1'b1; else frame_start = 1'b1;
    @(negedge CLK);
    frame_start  = 1'b0;
    frame_start2 = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    RST = 1'b0; frame_start = 0; frame_start2 = 0; abort = 0;
    samp_valid = 0; samp_bit = 0; PAR_EN = 0; PAR_TYP = 0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_pdata", 16'(P_DATA), 16'h0000);
    chk("rst_flags", {12'd0, data_valid, strt_glitch, par_err, stp_err}, 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);

    // 1: clean 8N1 0xA5
    snap();
    start_frame(0);
    chk("t1_busy", 16'(busy), 16'h1);
    bit3(1'b0);
    data_bits(8'hA5);
    bit3(1'b1);
    chk("t1_dv", 16'(data_valid), 16'h1);
    chk("t1_pdata", 16'(P_DATA), 16'h00A5);
    chk("t1_flags", {13'd0, strt_glitch, par_err, stp_err}, 16'h0);
    @(negedge CLK);
    chk("t1_dv_pulse", 16'(data_valid), 16'h0);
    chk("t1_busy_end", 16'(busy), 16'h0);
    chk("t1_counts", 16'({n_dv - b_dv, n_gl - b_gl, n_pe - b_pe, n_se - b_se} != 128'd0 ?
        ((n_dv - b_dv) * 1000 + (n_gl - b_gl) * 100 + (n_pe - b_pe) * 10 + (n_se - b_se)) : 0), 16'd1000);

    // 2: start glitch
    snap();
    start_frame(0);
    samp(1'b1); samp(1'b1); samp(1'b0);
    chk("t2_glitch", 16'(strt_glitch), 16'h1);
    chk("t2_busy", 16'(busy), 16'h0);
    chk("t2_dv", 16'(data_valid), 16'h0);
    chk("t2_pdata", 16'(P_DATA), 16'h00A5);
    @(negedge CLK);
    chk("t2_glitch_pulses", 16'(n_gl - b_gl), 16'd1);

    // 3: 8E1, data 0x03, parity sent 1 (even expects 0); PAR_EN dropped mid-frame
    snap();
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    start_frame(0);
    PAR_EN = 1'b0;
    bit3(1'b0);
    data_bits(8'h03);
    bit3(1'b1);
    chk("t3_no_early_end", 16'(n_dv - b_dv + n_pe - b_pe + n_se - b_se), 16'd0);
    bit3(1'b1);
    chk("t3_par_err", 16'(par_err), 16'h1);
    chk("t3_stp_err", 16'(stp_err), 16'h0);
    chk("t3_dv", 16'(data_valid), 16'h0);
    chk("t3_pdata", 16'(P_DATA), 16'h00A5);

    // 4: two stop bits, second voted 0
    start_frame(1);
    bit3(1'b0);
    data_bits(8'h81);
    bit3(1'b1);
    chk("t4_first_stop", {13'd0, stp_err2, data_valid2, busy2}, 16'h1);
    samp(1'b0); samp(1'b0); samp(1'b1);
    chk("t4_stp_err", 16'(stp_err2), 16'h1);
    chk("t4_par_dv", {14'd0, par_err2, data_valid2}, 16'h0);
    chk("t4_busy", 16'(busy2), 16'h0);
    chk("t4_pdata", 16'(P_DATA2), 16'h0000);

    // 5: one noisy sample per bit, frame_start mid-frame ignored
    snap();
    d = 8'h5A;
    start_frame(0);
    samp(1'b0); samp(1'b1); samp(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) frame_start = 1'b1;
      samp(d[i]);
      frame_start = 1'b0;
      samp(~d[i]);
      samp(d[i]);
    end
    samp(1'b1); samp(1'b0); samp(1'b1);
    chk("t5_dv", 16'(data_valid), 16'h1);
    chk("t5_pdata", 16'(P_DATA), 16'h005A);
    chk("t5_flags", {13'd0, strt_glitch, par_err, stp_err}, 16'h0);

    // 6: abort at DATA idx=4 together with frame_start, then clean 0x3C
    snap();
    start_frame(0);
    bit3(1'b0);
    for (int i = 0; i < 4; i++) bit3(1'b1);
    samp(1'b1);
    abort = 1'b1; frame_start = 1'b1; samp_valid = 1'b1; samp_bit = 1'b1;
    @(negedge CLK);
    abort = 1'b0; frame_start = 1'b0; samp_valid = 1'b0; samp_bit = 1'b0;
    chk("t6_busy", 16'(busy), 16'h0);
    bit3(1'b0);
    repeat (3) @(negedge CLK);
    chk("t6_no_pulses", 16'(n_dv - b_dv + n_gl - b_gl + n_pe - b_pe + n_se - b_se), 16'd0);
    chk("t6_pdata_hold", 16'(P_DATA), 16'h005A);
    start_frame(0);
    bit3(1'b0);
    data_bits(8'h3C);
    bit3(1'b1);
    chk("t6_dv", 16'(data_valid), 16'h1);
    chk("t6_pdata", 16'(P_DATA), 16'h003C);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
